// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
// Holds the FSM state encoding and the minimum-width helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

    // Bits needed to hold 10^nd - 1.
    function automatic int min_bin_w(input int nd);
        longint unsigned maxv;
        int              w;
        maxv = 1;
        for (int i = 0; i < nd; i++) begin
            maxv = maxv * 10;
        end
        maxv = maxv - 1;
        w = 1;
        for (int b = 1; b < 64; b++) begin
            if ((longint'(1) << w) <= maxv) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mul10_add.sv
// Combinational acc*10 + digit, truncated to BIN_W bits.
// The multiply is built from two shifts and an add.
module mul10_add
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0]   acc_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [BIN_W-1:0]   sum_o
);

    logic [BIN_W-1:0] x8;
    logic [BIN_W-1:0] x2;

    // acc*8 + acc*2 + digit, wrapping at BIN_W bits
    always_comb begin
        x8    = acc_i << 3;
        x2    = acc_i << 1;
        sum_o = x8 + x2 + BIN_W'(digit_i);
    end

endmodule

// File: rtl/bcd_to_binary_serial.sv
// Serial BCD-to-binary converter, one digit per clock, MSD first.
// Optional digit range check enabled by defining BCD_ERR_CHECK_EN.
module bcd_to_binary_serial
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DIGIT_W*NDIGITS-1:0] bcd_in,
    output logic                       busy,
    output logic                       done,
    output logic [BIN_W-1:0]           bin_out,
    output logic                       err
);

    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int SH_W  = DIGIT_W * NDIGITS;

    if (BIN_W < min_bin_w(NDIGITS)) begin : g_bad_width
        $error("BIN_W too small for NDIGITS");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [BIN_W-1:0]   acc_q, acc_d;
    logic               err_acc_q, err_acc_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;

    logic [DIGIT_W-1:0] digit;
    logic [BIN_W-1:0]   mac;
    logic               digit_bad;
    logic               err_fin;

    // The digit to consume always sits in the top nibble of the shifter
    assign digit = sh_q[SH_W-1 -: DIGIT_W];

`ifdef BCD_ERR_CHECK_EN
    assign digit_bad = (digit > DIGIT_W'(MAX_DIGIT));
`else
    assign digit_bad = 1'b0;
`endif

    assign err_fin = err_acc_q | digit_bad;

    mul10_add #(
        .BIN_W(BIN_W)
    ) u_mul10_add (
        .acc_i  (acc_q),
        .digit_i(digit),
        .sum_o  (mac)
    );

    // Next-state logic: load on accepted start, accumulate during CONV
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        err_acc_d = err_acc_q;
        bin_d     = bin_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d   = CONV;
                    sh_d      = bcd_in;
                    acc_d     = '0;
                    idx_d     = IDX_W'(NDIGITS - 1);
                    err_acc_d = 1'b0;
                end
            end
            CONV: begin
                acc_d     = mac;
                err_acc_d = err_fin;
                sh_d      = sh_q << DIGIT_W;
                idx_d     = idx_q - 1'b1;
                if (idx_q == '0) begin
                    state_d = DONE;
                    bin_d   = err_fin ? '0 : mac;
                    err_d   = err_fin;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sh_q      <= '0;
            acc_q     <= '0;
            err_acc_q <= 1'b0;
            bin_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            err_acc_q <= err_acc_d;
            bin_q     <= bin_d;
            err_q     <= err_d;
        end
    end

    assign busy    = (state_q == CONV);
    assign done    = (state_q == DONE);
    assign bin_out = bin_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Directed bench for the serial BCD-to-binary converter.
// Expected values are hand-computed decimal results.
module tb_bcd_to_binary_serial;

    localparam int ND = 4;
    localparam int BW = 14;

    logic          clock;
    logic          reset;
    logic          start;
    logic [15:0]   bcd_in;
    logic          busy;
    logic          done;
    logic [BW-1:0] bin_out;
    logic          err;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    bcd_to_binary_serial #(
        .NDIGITS(ND),
        .BIN_W  (BW)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .bcd_in (bcd_in),
        .busy   (busy),
        .done   (done),
        .bin_out(bin_out),
        .err    (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
    endtask

    // Starts a conversion and waits (bounded) for done.
    task automatic conv(input string tag, input logic [15:0] v,
                        input int exp_bin, input int exp_err);
        int n;
        bcd_in = v;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk({tag, ".busy0"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 12) begin
            step();
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(ND));
        chk({tag, ".bin"}, 32'(bin_out), 32'(exp_bin));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".busyD"}, 32'(busy), 32'd0);
        step();
        chk({tag, ".doneEnd"}, 32'(done), 32'd0);
        chk({tag, ".hold"}, 32'(bin_out), 32'(exp_bin));
    endtask

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        start     = 1'b0;
        bcd_in    = '0;
        @(negedge clock);
        step();
        step();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle("idle");
            chk("idle.bin", 32'(bin_out), 32'd0);
            chk("idle.err", 32'(err), 32'd0);
        end

        // Basic conversion with per-cycle busy check
        bcd_in = 16'h1234;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 1; i < ND; i++) begin
            chk("c1234.busy", 32'(busy), 32'd1);
            chk("c1234.done", 32'(done), 32'd0);
            step();
        end
        chk("c1234.busy3", 32'(busy), 32'd1);
        step();
        chk("c1234.doneK4", 32'(done), 32'd1);
        chk("c1234.busyK4", 32'(busy), 32'd0);
        chk("c1234.bin", 32'(bin_out), 32'd1234);
        chk("c1234.err", 32'(err), 32'd0);
        step();
        chk("c1234.doneOff", 32'(done), 32'd0);

        // Back-to-back with start held through DONE
        bcd_in = 16'h9999;
        start  = 1'b1;
        step();
        bcd_in = 16'h0000;
        for (int i = 1; i < ND; i++) begin
            step();
            chk("b2b.pre", 32'(done), 32'd0);
        end
        step();
        chk("b2b.done1", 32'(done), 32'd1);
        chk("b2b.bin1", 32'(bin_out), 32'd9999);
        step();
        start = 1'b0;
        chk("b2b.rebusy", 32'(busy), 32'd1);
        chk("b2b.nodone", 32'(done), 32'd0);
        for (int i = 1; i < ND; i++) begin
            step();
            chk("b2b.pre2", 32'(done), 32'd0);
        end
        step();
        chk("b2b.done2", 32'(done), 32'd1);
        chk("b2b.bin2", 32'(bin_out), 32'd0);
        step();

        // Start during CONV ignored, bcd_in changes ignored
        bcd_in = 16'h0042;
        start  = 1'b1;
        step();
        start  = 1'b0;
        bcd_in = 16'h7777;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("ign.pre", 32'(done), 32'd0);
        step();
        chk("ign.done", 32'(done), 32'd1);
        chk("ign.bin", 32'(bin_out), 32'd42);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ign.single", 32'(done), 32'd0);
        end

        // Non-decimal digit
`ifdef BCD_ERR_CHECK_EN
        conv("c12A4", 16'h12A4, 0, 1);
`else
        conv("c12A4", 16'h12A4, 1304, 0);
`endif

        // Reset mid-conversion
        bcd_in = 16'h5678;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        reset  = 1'b1;
        start  = 1'b1;
        step();
        reset  = 1'b0;
        start  = 1'b0;
        chk_idle("rst");
        chk("rst.bin", 32'(bin_out), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst.nodone", 32'(done), 32'd0);
        end
        conv("c0007", 16'h0007, 7, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
